// File: rtl/eight_data_decompress_unit.sv
// Eight-word decompress unit: rebuilds eight 32-bit words from one packed
// group (payload bytes + 2-bit size tag per word) through a two-stage
// valid/ready pipeline. Optional length checking is enabled by defining
// DECOMP_LEN_CHECK_EN; without it lenIn is ignored and errOut is tied low.
module eight_data_decompress_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [255:0]     dataIn,
  input  logic [15:0]      tagIn,
  input  logic [7:0]       lenIn,
  output logic             outValid,
  input  logic             outReady,
  output logic [255:0]     dataOut,
  output logic             errOut,
  output logic [CNT_W-1:0] grpCnt
);

  localparam int unsigned NWORDS = 8;
  localparam int unsigned OFF_W  = 6;

  // Packed size in bytes of one word for a given tag.
  function automatic logic [OFF_W-1:0] f_size(input logic [1:0] t);
    case (t)
      2'b00:   f_size = 6'd0;
      2'b01:   f_size = 6'd1;
      2'b10:   f_size = 6'd2;
      default: f_size = 6'd4;
    endcase
  endfunction

  // Zero-extension mask keeping only the bytes a word actually owns.
  function automatic logic [31:0] f_mask(input logic [1:0] t);
    case (t)
      2'b00:   f_mask = 32'h0000_0000;
      2'b01:   f_mask = 32'h0000_00FF;
      2'b10:   f_mask = 32'h0000_FFFF;
      default: f_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  logic                 r_a_valid;
  logic [255:0]         r_a_data;
  logic [15:0]          r_a_tag;
  logic                 r_b_valid;
  logic [255:0]         r_data_out;
  logic [CNT_W-1:0]     r_grp_cnt;

  logic                 w_b_free;
  logic                 w_a_adv;
  logic                 w_in_fire;
  logic [OFF_W-1:0]     w_off [NWORDS];
  logic [255:0]         w_dec;

  assign w_b_free  = !r_b_valid || outReady;
  assign w_a_adv   = r_a_valid && w_b_free;
  assign inReady   = !r_a_valid || w_b_free;
  assign w_in_fire = inValid && inReady;

  assign outValid = r_b_valid;
  assign dataOut  = r_data_out;
  assign grpCnt   = r_grp_cnt;

  // Stage A: capture the packed group; holds while stage B is stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a_valid <= 1'b0;
      r_a_data  <= '0;
      r_a_tag   <= '0;
    end else if (w_in_fire) begin
      r_a_valid <= 1'b1;
      r_a_data  <= dataIn;
      r_a_tag   <= tagIn;
    end else if (w_a_adv) begin
      r_a_valid <= 1'b0;
    end
  end

  // Running byte offset of each word inside the packed payload.
  always_comb begin
    w_off[0] = '0;
    for (int i = 1; i < NWORDS; i++) begin
      w_off[i] = w_off[i-1] + f_size(r_a_tag[2*i-2 +: 2]);
    end
  end

  // Per-word byte extraction; bytes past each word's size are masked off.
  always_comb begin
    w_dec = '0;
    for (int i = 0; i < NWORDS; i++) begin
      w_dec[32*i +: 32] = r_a_data[{w_off[i], 3'b000} +: 32] & f_mask(r_a_tag[2*i +: 2]);
    end
  end

  // Stage B: output register, only loaded when free so it holds under stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_b_valid  <= 1'b0;
      r_data_out <= '0;
    end else if (w_a_adv) begin
      r_b_valid  <= 1'b1;
      r_data_out <= w_dec;
    end else if (outReady) begin
      r_b_valid  <= 1'b0;
    end
  end

  // Count delivered groups; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grp_cnt <= '0;
    end else if (r_b_valid && outReady) begin
      r_grp_cnt <= r_grp_cnt + CNT_W'(1);
    end
  end

`ifdef DECOMP_LEN_CHECK_EN
  logic [7:0]       r_a_len;
  logic             r_err;
  logic             r_sticky;
  logic [OFF_W-1:0] w_tot;
  logic             w_len_err;

  assign w_tot     = w_off[NWORDS-1] + f_size(r_a_tag[15:14]);
  assign w_len_err = (r_a_len != {2'b00, w_tot}) || (r_a_len > 8'd32);
  assign errOut    = r_err;

  // Length register travels alongside the stage A payload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a_len <= '0;
    end else if (w_in_fire) begin
      r_a_len <= lenIn;
    end
  end

  // Error flag per group, plus a sticky bit that taints every later group.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err    <= 1'b0;
      r_sticky <= 1'b0;
    end else if (w_a_adv) begin
      r_err    <= w_len_err || r_sticky;
      r_sticky <= w_len_err || r_sticky;
    end
  end
`else
  logic w_len_unused;

  assign w_len_unused = ^lenIn;
  assign errOut       = 1'b0;
`endif

endmodule

// File: tb/tb_eight_data_decompress_unit.sv
// Directed bench for eight_data_decompress_unit: table of single groups,
// then streaming/backpressure and mid-operation reset sequences.
module tb_eight_data_decompress_unit;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned NVEC  = 8;
`ifdef DECOMP_LEN_CHECK_EN
  localparam bit LC = 1'b1;
`else
  localparam bit LC = 1'b0;
`endif

  typedef struct {
    logic [15:0]  tag;
    logic [7:0]   len;
    logic [255:0] data;
    logic [255:0] exp;
    logic         err;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             inValid;
  logic             inReady;
  logic [255:0]     dataIn;
  logic [15:0]      tagIn;
  logic [7:0]       lenIn;
  logic             outValid;
  logic             outReady;
  logic [255:0]     dataOut;
  logic             errOut;
  logic [CNT_W-1:0] grpCnt;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs [NVEC];
  int   sidx [5];

  eight_data_decompress_unit #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .inValid  (inValid),
    .inReady  (inReady),
    .dataIn   (dataIn),
    .tagIn    (tagIn),
    .lenIn    (lenIn),
    .outValid (outValid),
    .outReady (outReady),
    .dataOut  (dataOut),
    .errOut   (errOut),
    .grpCnt   (grpCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic vld);
    inValid = vld;
    tagIn   = v.tag;
    lenIn   = v.len;
    dataIn  = v.data;
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  initial begin
    logic [255:0] d;
    reset    = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    dataIn   = '0;
    tagIn    = '0;
    lenIn    = '0;

    // Nominal mixed-size group
    d = rnd256();
    d[119:0] = 120'hFEDCBA98_7654_32_1FEDCBA9_8765_43_21;
    vecs[0] = '{16'b1110011110010001, 8'h0F, d,
                256'hFEDCBA98_00007654_00000032_1FEDCBA9_00008765_00000043_00000000_00000021, 1'b0};
    // All zero-size words
    vecs[1] = '{16'h0000, 8'h00, rnd256(), 256'h0, 1'b0};
    // All full words
    d = rnd256();
    vecs[2] = '{16'hFFFF, 8'h20, d, d, 1'b0};
    // All single-byte words
    d = rnd256();
    d[63:0] = 64'h88776655_44332211;
    vecs[3] = '{16'h5555, 8'h08, d,
                256'h00000088_00000077_00000066_00000055_00000044_00000033_00000022_00000011, 1'b0};
    // All two-byte words
    d = rnd256();
    d[127:0] = 128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_1100;
    vecs[4] = '{16'hAAAA, 8'h10, d,
                256'h0000FFEE_0000DDCC_0000BBAA_00009988_00007766_00005544_00003322_00001100, 1'b0};
    // Alternating full / empty words
    d = rnd256();
    d[127:0] = 128'h44444444_33333333_22222222_11111111;
    vecs[5] = '{16'h3333, 8'h10, d,
                256'h00000000_44444444_00000000_33333333_00000000_22222222_00000000_11111111, 1'b0};
    // Length mismatch, then a clean group that sees the sticky error
    d = rnd256();
    vecs[6] = '{16'hFFFF, 8'h1F, d, d, LC};
    vecs[7] = '{16'h0000, 8'h00, rnd256(), 256'h0, LC};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outValid", 256'(outValid), 256'(0));
    chk("rst_dataOut", dataOut, 256'(0));
    chk("rst_errOut", 256'(errOut), 256'(0));
    chk("rst_grpCnt", 256'(grpCnt), 256'(0));
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Table: one group at a time, checking the 2-cycle latency
    outReady = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i], 1'b1);
      chk($sformatf("v%0d_inReady", i), 256'(inReady), 256'(1));
      @(posedge clk);
      #1;
      inValid = 1'b0;
      chk($sformatf("v%0d_early", i), 256'(outValid), 256'(0));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_outValid", i), 256'(outValid), 256'(1));
      chk($sformatf("v%0d_dataOut", i), dataOut, vecs[i].exp);
      chk($sformatf("v%0d_errOut", i), 256'(errOut), 256'(vecs[i].err));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_drained", i), 256'(outValid), 256'(0));
    end
    chk("table_grpCnt", 256'(grpCnt), 256'(NVEC));

    // Reset clears counter and any sticky error
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Streaming: 4 back-to-back groups with outReady high
    sidx = '{0, 2, 3, 4, 5};
    outReady = 1'b1;
    for (int g = 0; g < 5; g++) begin
      if (g < 4) drive(vecs[sidx[g]], 1'b1);
      else inValid = 1'b0;
      @(posedge clk);
      #1;
      if (g >= 1) begin
        chk($sformatf("s%0d_outValid", g - 1), 256'(outValid), 256'(1));
        chk($sformatf("s%0d_dataOut", g - 1), dataOut, vecs[sidx[g-1]].exp);
        chk($sformatf("s%0d_errOut", g - 1), 256'(errOut), 256'(0));
      end
    end

    // Backpressure: fill both stages, hold for 3 cycles
    outReady = 1'b0;
    drive(vecs[sidx[4]], 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      inValid = 1'b0;
      chk($sformatf("bp%0d_outValid", c), 256'(outValid), 256'(1));
      chk($sformatf("bp%0d_hold", c), dataOut, vecs[sidx[3]].exp);
      chk($sformatf("bp%0d_inReady", c), 256'(inReady), 256'(0));
    end
    chk("bp_grpCnt", 256'(grpCnt), 256'(3));
    outReady = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_next_data", dataOut, vecs[sidx[4]].exp);
    chk("bp_grpCnt4", 256'(grpCnt), 256'(4));
    @(posedge clk);
    #1;
    chk("bp_drained", 256'(outValid), 256'(0));
    chk("bp_grpCnt5", 256'(grpCnt), 256'(5));

    // Mid-operation reset with two groups in flight
    outReady = 1'b0;
    drive(vecs[1], 1'b1);
    @(posedge clk);
    #1;
    drive(vecs[3], 1'b1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    chk("mr_pre_outValid", 256'(outValid), 256'(1));
    #2;
    reset = 1'b0;
    #1;
    chk("mr_outValid", 256'(outValid), 256'(0));
    chk("mr_grpCnt", 256'(grpCnt), 256'(0));
    @(posedge clk);
    #1;
    reset    = 1'b1;
    outReady = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("mr_no_stale%0d", c), 256'(outValid), 256'(0));
    end

    // First group after reset release takes the normal latency
    drive(vecs[0], 1'b1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    chk("post_early", 256'(outValid), 256'(0));
    @(posedge clk);
    #1;
    chk("post_outValid", 256'(outValid), 256'(1));
    chk("post_dataOut", dataOut, vecs[0].exp);
    chk("post_errOut", 256'(errOut), 256'(0));
    @(posedge clk);
    #1;
    chk("post_grpCnt", 256'(grpCnt), 256'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
